// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types, constants and event priority for the hazard controller
package hazard_stall_ctrl_pkg;

  // Controller FSM: IDLE passes or takes the first bubble, LDSTALL counts the remaining bubbles
  typedef enum logic {
    IDLE    = 1'b0,
    LDSTALL = 1'b1
  } state_t;

  // Register $0 is hard-wired to zero, so a load to it never creates a dependency
  localparam int unsigned REG_ZERO = 0;

  // Per-cycle event after priority resolution (reset is handled separately, above all of these)
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_BRANCH = 2'd1,
    EV_STALL  = 2'd2,
    EV_FREEZE = 2'd3
  } event_t;

  // Memory freeze beats load-use stall, which beats branch flush
  function automatic event_t pick_event(input logic freeze, input logic stall, input logic branch);
    event_t ev;
    ev = EV_NONE;
    if (freeze) begin
      ev = EV_FREEZE;
    end else if (stall) begin
      ev = EV_STALL;
    end else if (branch) begin
      ev = EV_BRANCH;
    end
    return ev;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle; stats outputs present when HAZARD_STATS_EN is defined
interface hazard_stall_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);

  logic                      ID_EX_memread_i;
  logic [REG_AW-1:0]         ID_EX_RT_i;
  logic [NUM_SRC*REG_AW-1:0] IF_ID_src_i;
  logic [NUM_SRC-1:0]        IF_ID_src_valid_i;
  logic                      dmem_stall_i;
  logic                      branch_taken_i;
  logic                      ID_EX_nop_o;
  logic                      IF_ID_write_o;
  logic                      pc_write_o;
  logic                      IF_ID_flush_o;
  logic                      pipe_freeze_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]               stall_cycles_o;
  logic [31:0]               freeze_cycles_o;

  modport master (
    output ID_EX_memread_i, ID_EX_RT_i, IF_ID_src_i, IF_ID_src_valid_i, dmem_stall_i, branch_taken_i,
    input  ID_EX_nop_o, IF_ID_write_o, pc_write_o, IF_ID_flush_o, pipe_freeze_o,
    input  stall_cycles_o, freeze_cycles_o
  );

  modport slave (
    input  ID_EX_memread_i, ID_EX_RT_i, IF_ID_src_i, IF_ID_src_valid_i, dmem_stall_i, branch_taken_i,
    output ID_EX_nop_o, IF_ID_write_o, pc_write_o, IF_ID_flush_o, pipe_freeze_o,
    output stall_cycles_o, freeze_cycles_o
  );
`else
  modport master (
    output ID_EX_memread_i, ID_EX_RT_i, IF_ID_src_i, IF_ID_src_valid_i, dmem_stall_i, branch_taken_i,
    input  ID_EX_nop_o, IF_ID_write_o, pc_write_o, IF_ID_flush_o, pipe_freeze_o
  );

  modport slave (
    input  ID_EX_memread_i, ID_EX_RT_i, IF_ID_src_i, IF_ID_src_valid_i, dmem_stall_i, branch_taken_i,
    output ID_EX_nop_o, IF_ID_write_o, pc_write_o, IF_ID_flush_o, pipe_freeze_o
  );
`endif

endinterface

// File: rtl/hazard_stall_ctrl_src_cmp.sv
// rtl/hazard_stall_ctrl_src_cmp.sv - valid-qualified compare of the load destination against all ID sources
module hazard_stall_ctrl_src_cmp #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic [REG_AW-1:0]         rt,
  input  logic [NUM_SRC*REG_AW-1:0] src,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic                      hit
);

  // OR over every source that the ID instruction actually reads
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_valid[k] && (src[k*REG_AW +: REG_AW] == rt)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, memory freeze and branch flush control; HAZARD_STATS_EN adds cycle counters
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_hit;
  logic             hazard;
  logic             stall_req;
  event_t           ev;

  logic nop, if_id_write, pc_write, flush, freeze;

  hazard_stall_ctrl_src_cmp #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC)
  ) u_src_cmp (
    .rt        (bus.ID_EX_RT_i),
    .src       (bus.IF_ID_src_i),
    .src_valid (bus.IF_ID_src_valid_i),
    .hit       (src_hit)
  );

  assign hazard    = bus.ID_EX_memread_i && (bus.ID_EX_RT_i != REG_AW'(REG_ZERO)) && src_hit;
  assign stall_req = (state_q == LDSTALL) || hazard;
  assign ev        = pick_event(bus.dmem_stall_i, stall_req, bus.branch_taken_i);

  // Next state, bubble counter and all pipeline enables from the resolved event
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nop         = 1'b0;
    if_id_write = 1'b1;
    pc_write    = 1'b1;
    flush       = 1'b0;
    freeze      = 1'b0;
    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (ev)
        EV_FREEZE: begin
          freeze      = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        EV_STALL: begin
          nop         = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (state_q == LDSTALL) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = IDLE;
            end
          end else if (LOAD_LAT > 1) begin
            // first bubble is issued now, the counter covers the rest
            state_d = LDSTALL;
            cnt_d   = CNT_LOAD;
          end
        end
        EV_BRANCH: begin
          flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State and bubble-counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ID_EX_nop_o   = nop;
  assign bus.IF_ID_write_o = if_id_write;
  assign bus.pc_write_o    = pc_write;
  assign bus.IF_ID_flush_o = flush;
  assign bus.pipe_freeze_o = freeze;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] freeze_cycles_q;

  // Saturating counts of bubble cycles and freeze cycles since reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q  <= '0;
      freeze_cycles_q <= '0;
    end else begin
      if (nop && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (freeze && (freeze_cycles_q != 32'hFFFF_FFFF)) begin
        freeze_cycles_q <= freeze_cycles_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles_o  = stall_cycles_q;
  assign bus.freeze_cycles_o = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl at LOAD_LAT=1 and LOAD_LAT=3
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  // expected {nop, IF_ID_write, pc_write, flush, freeze} per cycle, one queue per DUT
  logic [4:0] exp_q1[$];
  logic [4:0] exp_q3[$];

  // reference model state, index 0 = LOAD_LAT 1, index 1 = LOAD_LAT 3
  bit m_ldstall[2];
  int m_cnt[2];
  int m_stall_cyc[2];
  int m_frz_cyc[2];

  hazard_stall_ctrl_if #(.REG_AW(5), .NUM_SRC(2)) if_l1 ();
  hazard_stall_ctrl_if #(.REG_AW(5), .NUM_SRC(2)) if_l3 ();

  hazard_stall_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(3)) u_dut_l1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_l1)
  );

  hazard_stall_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(3)) u_dut_l3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One clock: drive both DUTs, predict, compare mid-cycle, advance the model at the edge
  task automatic cyc(input string name, input logic r, input logic ml, input logic [4:0] rt,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] v,
                     input logic dm, input logic br);
    bit         haz;
    int         lat;
    logic [4:0] e;
    logic [4:0] got;
    if_l1.ID_EX_memread_i = ml;  if_l3.ID_EX_memread_i = ml;
    if_l1.ID_EX_RT_i = rt;       if_l3.ID_EX_RT_i = rt;
    if_l1.IF_ID_src_i = {s1, s0}; if_l3.IF_ID_src_i = {s1, s0};
    if_l1.IF_ID_src_valid_i = v;  if_l3.IF_ID_src_valid_i = v;
    if_l1.dmem_stall_i = dm;     if_l3.dmem_stall_i = dm;
    if_l1.branch_taken_i = br;   if_l3.branch_taken_i = br;
    rst = r;
    haz = ml && (rt != 5'd0) && ((v[0] && (s0 == rt)) || (v[1] && (s1 == rt)));
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      if (r) begin
        e = 5'b01100;
      end else if (dm) begin
        e = 5'b00001;
      end else if (m_ldstall[i] || haz) begin
        e = 5'b10000;
      end else if (br) begin
        e = 5'b01110;
      end else begin
        e = 5'b01100;
      end
      if (i == 0) exp_q1.push_back(e);
      else        exp_q3.push_back(e);
    end
    #3;
    got = {if_l1.ID_EX_nop_o, if_l1.IF_ID_write_o, if_l1.pc_write_o, if_l1.IF_ID_flush_o, if_l1.pipe_freeze_o};
    check_eq($sformatf("%s/L1", name), 32'(got), 32'(exp_q1.pop_front()));
    got = {if_l3.ID_EX_nop_o, if_l3.IF_ID_write_o, if_l3.pc_write_o, if_l3.IF_ID_flush_o, if_l3.pipe_freeze_o};
    check_eq($sformatf("%s/L3", name), 32'(got), 32'(exp_q3.pop_front()));
`ifdef HAZARD_STATS_EN
    check_eq($sformatf("%s/L1 stall_cycles", name), if_l1.stall_cycles_o, 32'(m_stall_cyc[0]));
    check_eq($sformatf("%s/L1 freeze_cycles", name), if_l1.freeze_cycles_o, 32'(m_frz_cyc[0]));
    check_eq($sformatf("%s/L3 stall_cycles", name), if_l3.stall_cycles_o, 32'(m_stall_cyc[1]));
    check_eq($sformatf("%s/L3 freeze_cycles", name), if_l3.freeze_cycles_o, 32'(m_frz_cyc[1]));
`endif
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      if (r) begin
        m_ldstall[i] = 0; m_cnt[i] = 0; m_stall_cyc[i] = 0; m_frz_cyc[i] = 0;
      end else if (dm) begin
        m_frz_cyc[i]++;
      end else if (m_ldstall[i]) begin
        m_stall_cyc[i]++;
        if (m_cnt[i] == 1) m_ldstall[i] = 0;
        m_cnt[i]--;
      end else if (haz) begin
        m_stall_cyc[i]++;
        if (lat > 1) begin
          m_ldstall[i] = 1; m_cnt[i] = lat - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) cyc(name, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ldstall[i] = 0; m_cnt[i] = 0; m_stall_cyc[i] = 0; m_frz_cyc[i] = 0;
    end
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    cyc("reset", 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
    idle("idle", 1);

    cyc("hazard_src0", 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 2'b01, 1'b0, 1'b0);
    idle("after_hazard", 3);

    cyc("rt_zero", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
    cyc("invalid_src", 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 2'b01, 1'b0, 1'b0);
    cyc("no_memread", 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 2'b11, 1'b0, 1'b0);

    cyc("hazard_src1", 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 2'b10, 1'b0, 1'b0);
    idle("after_src1", 3);

    cyc("frz_hazard", 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
    cyc("frz", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    cyc("frz", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1);
    idle("after_frz", 3);

    cyc("haz_branch", 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 2'b11, 1'b0, 1'b1);
    cyc("stall_branch", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    idle("after_hb", 2);
    cyc("branch", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    cyc("frz_branch", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1);
    idle("after_branch", 1);

    cyc("rst_mid", 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 2'b01, 1'b0, 1'b0);
    cyc("rst_mid", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    idle("after_rst", 2);

    for (int i = 0; i < 60; i++) begin
      cyc("random", ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end
    idle("drain", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
